// File: rtl/button_debounce_bank_pkg.sv
// Shared types and default constants for the button debounce bank.
// Holds the per-channel state encoding used by the channel FSM and by the debug state bus.
package button_debounce_bank_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } ch_state_t;

    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 2400000;
    localparam int DEF_LONG_CYCLES     = 12000000;
    localparam int DEF_MIN_RST_CYCLES  = 16;
    localparam int DEF_CNT_W           = 24;

endpackage

// File: rtl/button_debounce_bank_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, long-press counter
// and registered one-cycle press/release/long pulses.
module debounce_channel
    import button_debounce_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_raw,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long,
    output logic [1:0] o_state
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(LONG_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    ch_state_t        r_state;
    ch_state_t        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] r_long_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             w_level;
    logic             w_press_evt;
    logic             w_release_evt;
    logic             w_long_evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // r_cnt counts consecutive synchronized samples that disagree with the accepted level.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_next_state = PRESS_WAIT;
                    w_next_cnt   = CNT_W'(1);
                end else begin
                    w_next_cnt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_next_state = PRESSED;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_next_state = RELEASE_WAIT;
                    w_next_cnt   = CNT_W'(1);
                end else begin
                    w_next_cnt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_next_state = PRESSED;
                    w_next_cnt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Events are decoded from the current state against the registered level, so
    // long (PRESSED only) and release (IDLE only) can never coincide.
    always_comb begin
        w_level       = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
        w_press_evt   = (r_state == PRESSED) && !r_level;
        w_release_evt = (r_state == IDLE) && r_level;
        w_long_evt    = (r_state == PRESSED) && r_level && (r_long_cnt == LONG_LAST);
    end

    // Long counter starts on the press-pulse cycle, holds in RELEASE_WAIT, saturates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_long_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_long_cnt <= '0;
        end else if ((r_state == PRESSED) && r_level && (r_long_cnt != LONG_END)) begin
            r_long_cnt <= r_long_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_level   <= w_level;
            r_press   <= w_press_evt;
            r_release <= w_release_evt;
            r_long    <= w_long_evt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_state   = r_state;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent debounced button channels plus a stretched active-low
// system reset request driven by channel 0.
module button_debounce_bank
    import button_debounce_bank_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int MIN_RST_CYCLES  = DEF_MIN_RST_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_CH-1:0]     btnRaw,
    output logic [NUM_CH-1:0]     btnLevel,
    output logic [NUM_CH-1:0]     btnPress,
    output logic [NUM_CH-1:0]     btnRelease,
    output logic [NUM_CH-1:0]     btnLong,
    output logic                  resetPulse,
    output logic [2*NUM_CH-1:0]   dbgState
);

    localparam int               RST_W    = $clog2(MIN_RST_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(MIN_RST_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_END  = RST_W'(MIN_RST_CYCLES);

    logic [NUM_CH-1:0] w_level;
    logic              r_rst_low;
    logic [RST_W-1:0]  r_rst_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .i_clk     (clk),
            .i_rst_n   (resetN),
            .i_raw     (btnRaw[g]),
            .o_level   (w_level[g]),
            .o_press   (btnPress[g]),
            .o_release (btnRelease[g]),
            .o_long    (btnLong[g]),
            .o_state   (dbgState[2*g +: 2])
        );
    end

    assign btnLevel = w_level;

    // r_rst_cnt counts cycles since resetPulse went low; a press seen while the
    // stretch is idle (re)starts it, so the output stays low without a gap.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rst_low <= 1'b0;
            r_rst_cnt <= '0;
        end else if (!r_rst_low) begin
            if (w_level[0]) begin
                r_rst_low <= 1'b1;
                r_rst_cnt <= RST_W'(1);
            end
        end else begin
            if (r_rst_cnt != RST_END) begin
                r_rst_cnt <= r_rst_cnt + RST_W'(1);
            end
            if (!w_level[0] && (r_rst_cnt >= RST_LAST)) begin
                r_rst_low <= 1'b0;
            end
        end
    end

    assign resetPulse = ~(w_level[0] | r_rst_low);

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with small debounce/long/stretch constants.
module tb_button_debounce_bank;

  localparam int NUM_CH  = 2;
  localparam int DEB     = 8;
  localparam int LONG    = 32;
  localparam int MIN_RST = 16;
  localparam int CNT_W   = 8;

  logic                clk = 1'b0;
  logic                resetN;
  logic [NUM_CH-1:0]   btnRaw;
  logic [NUM_CH-1:0]   btnLevel;
  logic [NUM_CH-1:0]   btnPress;
  logic [NUM_CH-1:0]   btnRelease;
  logic [NUM_CH-1:0]   btnLong;
  logic                resetPulse;
  logic [2*NUM_CH-1:0] dbgState;

  int n_checks = 0;
  int n_errors = 0;
  int press_n[NUM_CH];
  int rel_n[NUM_CH];
  int long_n[NUM_CH];
  int overlap_n = 0;
  int rp_run = 0;
  int rp_last_run = 0;
  int rp_low_samples = 0;

  // clock / reset block
  always #5 clk = ~clk;

  button_debounce_bank #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .MIN_RST_CYCLES  (MIN_RST),
    .CNT_W           (CNT_W)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .btnRaw     (btnRaw),
    .btnLevel   (btnLevel),
    .btnPress   (btnPress),
    .btnRelease (btnRelease),
    .btnLong    (btnLong),
    .resetPulse (resetPulse),
    .dbgState   (dbgState)
  );

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      press_n[i] = 0;
      rel_n[i]   = 0;
      long_n[i]  = 0;
    end
  end

  // event monitor: pulse counts and resetPulse low-run lengths
  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (btnPress[ch] === 1'b1) press_n[ch]++;
      if (btnRelease[ch] === 1'b1) rel_n[ch]++;
      if (btnLong[ch] === 1'b1) long_n[ch]++;
      if (btnLong[ch] === 1'b1 && btnRelease[ch] === 1'b1) overlap_n++;
    end
    if (resetPulse === 1'b0) begin
      rp_run++;
      rp_low_samples++;
    end else begin
      if (rp_run > 0) rp_last_run = rp_run;
      rp_run = 0;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rp_high(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (resetPulse !== 1'b1 && k < max_cycles) begin
      tick(1);
      k++;
    end
    check(tag, {31'd0, resetPulse}, 32'd1);
  endtask

  initial begin
    resetN = 1'b0;
    btnRaw = '0;
    tick(3);
    check("rst_level",   {30'd0, btnLevel},   32'd0);
    check("rst_press",   {30'd0, btnPress},   32'd0);
    check("rst_release", {30'd0, btnRelease}, 32'd0);
    check("rst_long",    {30'd0, btnLong},    32'd0);
    check("rst_pulse",   {31'd0, resetPulse}, 32'd1);
    check("rst_state",   {28'd0, dbgState},   32'd0);
    resetN = 1'b1;
    tick(3);

    // short glitch on ch0 is rejected
    btnRaw[0] = 1'b1;
    tick(5);
    btnRaw[0] = 1'b0;
    tick(20);
    check("glitch_level",  {31'd0, btnLevel[0]}, 32'd0);
    check("glitch_press",  press_n[0],           32'd0);
    check("glitch_rp_low", rp_low_samples,       32'd0);
    check("glitch_state",  {30'd0, dbgState[1:0]}, 32'd0);

    // ch0 press latency 10, then release
    btnRaw[0] = 1'b1;
    tick(10);
    check("press0_early", {31'd0, btnLevel[0]}, 32'd0);
    tick(1);
    check("press0_level", {31'd0, btnLevel[0]},   32'd1);
    check("press0_pulse", {31'd0, btnPress[0]},   32'd1);
    check("press0_rp",    {31'd0, resetPulse},    32'd0);
    check("press0_state", {30'd0, dbgState[1:0]}, 32'd2);
    tick(1);
    check("press0_once",  {31'd0, btnPress[0]},   32'd0);
    check("press0_count", press_n[0],             32'd1);
    btnRaw[0] = 1'b0;
    tick(10);
    check("rel0_early",   {31'd0, btnLevel[0]},   32'd1);
    tick(1);
    check("rel0_level",   {31'd0, btnLevel[0]},   32'd0);
    check("rel0_pulse",   {31'd0, btnRelease[0]}, 32'd1);
    tick(1);
    check("rel0_once",    {31'd0, btnRelease[0]}, 32'd0);
    wait_rp_high("rp_return", 30);
    check("rp_stretch",   {31'd0, rp_last_run >= MIN_RST}, 32'd1);
    check("rel0_count",   rel_n[0], 32'd1);

    // ch1 press with a 3-cycle bounce, long press after 32 held cycles
    btnRaw[1] = 1'b1;
    tick(11);
    check("press1_pulse", {31'd0, btnPress[1]}, 32'd1);
    tick(5);
    btnRaw[1] = 1'b0;
    tick(3);
    btnRaw[1] = 1'b1;
    tick(26);
    check("long1_early",  {31'd0, btnLong[1]}, 32'd0);
    tick(1);
    check("long1_pulse",  {31'd0, btnLong[1]}, 32'd1);
    tick(1);
    check("long1_once",   {31'd0, btnLong[1]}, 32'd0);
    tick(40);
    check("long1_count",  long_n[1],  32'd1);
    check("bounce1_norel", rel_n[1],  32'd0);
    check("bounce1_level", {31'd0, btnLevel[1]}, 32'd1);
    btnRaw[1] = 1'b0;
    tick(15);
    check("rel1_count",   rel_n[1],   32'd1);
    check("rel1_level",   {31'd0, btnLevel[1]}, 32'd0);
    check("long1_after",  long_n[1],  32'd1);
    check("rp_ch1_high",  {31'd0, resetPulse}, 32'd1);

    // both channels rise on the same edge
    btnRaw = 2'b11;
    tick(11);
    check("both_press",   {30'd0, btnPress}, 32'd3);
    check("both_level",   {30'd0, btnLevel}, 32'd3);
    tick(1);
    check("both_once",    {30'd0, btnPress}, 32'd0);
    btnRaw = 2'b00;
    tick(15);
    check("both_rel0",    rel_n[0], 32'd2);
    check("both_rel1",    rel_n[1], 32'd2);
    wait_rp_high("rp_return2", 30);
    check("rp_stretch2",  {31'd0, rp_last_run >= MIN_RST}, 32'd1);

    // reset mid-debounce aborts, held button is a fresh press afterwards
    btnRaw[0] = 1'b1;
    tick(5);
    resetN = 1'b0;
    tick(1);
    check("abort_level",  {30'd0, btnLevel},   32'd0);
    check("abort_press",  {30'd0, btnPress},   32'd0);
    check("abort_rp",     {31'd0, resetPulse}, 32'd1);
    check("abort_state",  {28'd0, dbgState},   32'd0);
    tick(2);
    resetN = 1'b1;
    tick(10);
    check("fresh_early",  {31'd0, btnPress[0]}, 32'd0);
    check("abort_noevt",  press_n[0],           32'd2);
    tick(1);
    check("fresh_press",  {31'd0, btnPress[0]}, 32'd1);
    tick(1);
    check("fresh_count",  press_n[0],           32'd3);
    btnRaw[0] = 1'b0;
    tick(15);
    check("no_long_rel_overlap", overlap_n, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
